// File: rtl/rr_memory_arbiter.sv
// Round-robin arbiter sharing one memory bus among NUM_PORTS requesters,
// with a per-transaction watchdog that aborts hung accesses with an error response.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | no owner; pick next valid requester starting at ptr
//   S_ISSUE | latched request driven to memory, waiting for mem_ready_i
//   S_RESP  | one-cycle ready (and error) pulse to the owner
module rr_memory_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  input  logic [NUM_PORTS-1:0]             req_write_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wr_data_i,
  output logic [NUM_PORTS-1:0]             req_ready_o,
  output logic [NUM_PORTS-1:0]             req_error_o,
  output logic [DATA_WIDTH-1:0]            req_rd_data_o,
  output logic                             mem_valid_o,
  output logic                             mem_write_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wr_data_o,
  input  logic                             mem_ready_i,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data_i,
  output logic [NUM_PORTS-1:0]             grant_o,
  output logic                             busy_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic                   write_q, write_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand_idx;
  int                     cand;
  logic                   pick_write;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic [DATA_WIDTH-1:0]  pick_wdata;

  // Rotating priority search: ptr, ptr+1, ... wrapping at NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_valid_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Constant-index mux keeps the part-selects static.
  always_comb begin
    pick_write = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_write = req_write_i[k];
        pick_addr  = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    timer_d = timer_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_ISSUE;
          win_d   = pick_idx;
          write_d = pick_write;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          timer_d = '0;
        end
      end
      S_ISSUE: begin
        if (mem_ready_i) begin
          state_d = S_RESP;
          rdata_d = mem_rd_data_i;
          err_d   = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = (win_q == LAST_PORT) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode registered state only; no input-to-output paths.
  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    req_error_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (win_q == IDX_W'(k)) begin
        grant_o[k]     = (state_q == S_ISSUE);
        req_ready_o[k] = (state_q == S_RESP);
        req_error_o[k] = (state_q == S_RESP) && err_q;
      end
    end
  end

  assign mem_valid_o   = (state_q == S_ISSUE);
  assign mem_write_o   = (state_q == S_ISSUE) && write_q;
  assign mem_addr_o    = (state_q == S_ISSUE) ? addr_q  : '0;
  assign mem_wr_data_o = (state_q == S_ISSUE) ? wdata_q : '0;
  assign req_rd_data_o = rdata_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rr_memory_arbiter.sv
// Directed bench for rr_memory_arbiter: 4 ports, 32-bit, watchdog of 8 cycles.
module tb_rr_memory_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NP-1:0]     req_valid_i, req_write_i;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP*DW-1:0]  req_wr_data_i;
  logic [NP-1:0]     req_ready_o, req_error_o, grant_o;
  logic [DW-1:0]     req_rd_data_o, mem_wr_data_o, mem_rd_data_i;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_valid_o, mem_write_o, mem_ready_i, busy_o;

  int errors = 0;
  int checks = 0;
  int ready_cnt[NP];
  int cnt;
  logic [NP-1:0] exp_oh;

  rr_memory_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wr_data_i(req_wr_data_i),
    .req_ready_o(req_ready_o), .req_error_o(req_error_o),
    .req_rd_data_o(req_rd_data_o),
    .mem_valid_o(mem_valid_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i       = 1'b1;
    req_valid_i   = '0;
    req_write_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    mem_ready_i   = 1'b0;
    mem_rd_data_i = '0;
    for (int k = 0; k < NP; k++) begin
      req_addr_i[k*AW +: AW] = AW'(k) * 32'h100;
      ready_cnt[k] = 0;
    end
    tick();
    tick();
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
    reset_i = 1'b0;
    tick();

    // Round robin: all ports continuously valid, ptr starts at 0
    req_valid_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_oh = NP'(1 << (i % NP));
      tick();
      chk("rr_grant", grant_o, exp_oh);
      chk("rr_addr", mem_addr_o, 32'(i % NP) * 32'h100);
      mem_ready_i   = 1'b1;
      mem_rd_data_i = 32'hC0DE_0000 + 32'(i);
      tick();
      chk("rr_ready", req_ready_o, exp_oh);
      chk("rr_rdata", req_rd_data_o, 32'hC0DE_0000 + 32'(i));
      if (i < NP)
        for (int k = 0; k < NP; k++) ready_cnt[k] += int'(req_ready_o[k]);
      mem_ready_i = 1'b0;
      if (i == 4) req_valid_i = '0;
      tick();
      chk("rr_idle_busy", busy_o, 0);
    end
    for (int k = 0; k < NP; k++) chk("rr_fair_count", ready_cnt[k], 1);

    // Single read from port 2 (ptr now 1)
    req_valid_i = 4'b0100;
    req_addr_i[2*AW +: AW] = 32'h1000;
    tick();
    chk("rd_mem_valid", mem_valid_o, 1);
    chk("rd_mem_addr", mem_addr_o, 32'h1000);
    chk("rd_mem_write", mem_write_o, 0);
    chk("rd_grant", grant_o, 4'b0100);
    mem_ready_i   = 1'b1;
    mem_rd_data_i = 32'hDEADBEEF;
    tick();
    chk("rd_ready", req_ready_o, 4'b0100);
    chk("rd_error", req_error_o, 0);
    chk("rd_data", req_rd_data_o, 32'hDEADBEEF);
    mem_ready_i = 1'b0;
    req_valid_i = '0;
    tick();
    chk("rd_ready_drop", req_ready_o, 0);

    // Write with 5 cycles of wait states, port 1 (ptr now 3)
    req_valid_i = 4'b0010;
    req_write_i = 4'b0010;
    req_addr_i[1*AW +: AW]    = 32'h20;
    req_wr_data_i[1*DW +: DW] = 32'hA5A5A5A5;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wr_mem_valid", mem_valid_o, 1);
      chk("wr_mem_write", mem_write_o, 1);
      chk("wr_mem_addr", mem_addr_o, 32'h20);
      chk("wr_mem_data", mem_wr_data_o, 32'hA5A5A5A5);
      chk("wr_no_early_ready", req_ready_o, 0);
      if (i == 4) mem_ready_i = 1'b1;
      tick();
    end
    chk("wr_ready", req_ready_o, 4'b0010);
    chk("wr_error", req_error_o, 0);
    mem_ready_i = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    tick();
    chk("wr_single_pulse", req_ready_o, 0);
    chk("wr_idle_busy", busy_o, 0);

    // Watchdog: port 3, memory never answers (ptr now 2)
    req_valid_i = 4'b1000;
    req_addr_i[3*AW +: AW] = 32'h300;
    tick();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_valid_o) break;
      cnt++;
      tick();
    end
    chk("to_valid_cycles", cnt, 8);
    chk("to_ready", req_ready_o, 4'b1000);
    chk("to_error", req_error_o, 4'b1000);
    chk("to_rdata", req_rd_data_o, 0);
    req_valid_i = '0;
    tick();
    chk("to_ready_drop", req_ready_o, 0);
    chk("to_error_drop", req_error_o, 0);
    req_valid_i = 4'b0001;
    req_addr_i[0*AW +: AW] = 32'h40;
    tick();
    chk("post_to_grant", grant_o, 4'b0001);
    mem_ready_i   = 1'b1;
    mem_rd_data_i = 32'h1234;
    tick();
    chk("post_to_ready", req_ready_o, 4'b0001);
    chk("post_to_error", req_error_o, 0);
    chk("post_to_rdata", req_rd_data_o, 32'h1234);
    mem_ready_i = 1'b0;
    req_valid_i = '0;
    tick();

    // Valid dropped while granted; stray mem_ready in IDLE
    req_valid_i = 4'b0001;
    tick();
    chk("drop_grant", grant_o, 4'b0001);
    req_valid_i = '0;
    tick();
    tick();
    chk("drop_still_issue", mem_valid_o, 1);
    mem_ready_i   = 1'b1;
    mem_rd_data_i = 32'h55;
    tick();
    chk("drop_ready", req_ready_o, 4'b0001);
    chk("drop_rdata", req_rd_data_o, 32'h55);
    tick();
    chk("stray_busy", busy_o, 0);
    chk("stray_ready", req_ready_o, 0);
    tick();
    chk("stray_busy2", busy_o, 0);
    chk("stray_mem_valid", mem_valid_o, 0);
    mem_ready_i = 1'b0;

    // Async reset in the middle of ISSUE (ptr now 1)
    req_valid_i = 4'b0100;
    tick();
    chk("mid_rst_pre_valid", mem_valid_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_mem_valid", mem_valid_o, 0);
    chk("mid_rst_grant", grant_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    tick();
    chk("mid_rst_no_ready", req_ready_o, 0);
    reset_i     = 1'b0;
    req_valid_i = 4'b1110;
    tick();
    chk("post_rst_grant", grant_o, 4'b0010);
    mem_ready_i = 1'b1;
    tick();
    chk("post_rst_ready", req_ready_o, 4'b0010);
    mem_ready_i = 1'b0;
    req_valid_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
